ar_rr_arbiter: RTL and testbench

Round-robin read-address arbiter for the AXI interconnect. It shares the single AR path toward the slave decoder between master 0 and master 1. Each read is held as one outstanding transaction until its last R beat has been handshaken. Master AR payload is registered at acceptance and replayed to the decoder side until the addressed slave accepts it. The R-channel burst length is also checked against the granted ARLEN.

---
 rtl/ar_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_ar_rr_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ar_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ar_rr_arbiter
// Purpose  : Two-master round-robin AR arbiter. It holds one outstanding read
//            and checks the R burst length against the granted ARLEN.
// Revision : 1.0 - initial release
// ============================================================================
module ar_rr_arbiter #(
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ID_BITS-1:0]   ARID_M0,
  input  logic [ID_BITS-1:0]   ARID_M1,
  input  logic [ADDR_BITS-1:0] ARADDR_M0,
  input  logic [ADDR_BITS-1:0] ARADDR_M1,
  input  logic [LEN_BITS-1:0]  ARLEN_M0,
  input  logic [LEN_BITS-1:0]  ARLEN_M1,
  input  logic [SIZE_BITS-1:0] ARSIZE_M0,
  input  logic [SIZE_BITS-1:0] ARSIZE_M1,
  input  logic [1:0]           ARBURST_M0,
  input  logic [1:0]           ARBURST_M1,
  input  logic                 ARVALID_M0,
  input  logic                 ARVALID_M1,
  output logic                 ARREADY_M0,
  output logic                 ARREADY_M1,
  output logic [ID_BITS+3:0]   IDS_M,
  output logic [ADDR_BITS-1:0] ADDR_M,
  output logic [LEN_BITS-1:0]  LEN_M,
  output logic [SIZE_BITS-1:0] SIZE_M,
  output logic [1:0]           BURST_M,
  output logic                 VALID_M,
  input  logic                 READY_M,
  input  logic                 RVALID_M,
  input  logic                 RREADY_M,
  input  logic                 RLAST_M,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic                 len_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [3:0]        c_tag_m0 = 4'b0001;
  localparam logic [3:0]        c_tag_m1 = 4'b0010;
  localparam logic [LEN_BITS:0] c_one    = {{LEN_BITS{1'b0}}, 1'b1};

  state_t                 r_state;
  logic                   r_prio;  // 1 when M1 wins a tie
  logic [LEN_BITS:0]      r_beats;
  logic [ID_BITS+3:0]     r_ids;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [LEN_BITS-1:0]    r_len;
  logic [SIZE_BITS-1:0]   r_size;
  logic [1:0]             r_burst;
  logic                   r_valid;
  logic [1:0]             r_grant;
  logic                   r_len_err;

  logic                   w_idle;
  logic                   w_win0;
  logic                   w_win1;
  logic                   w_rbeat;
  logic [LEN_BITS:0]      w_len_ext;

  assign w_idle    = (r_state == S_IDLE);
  assign w_win0    = ARVALID_M0 & (~ARVALID_M1 | ~r_prio);
  assign w_win1    = ARVALID_M1 & (~ARVALID_M0 | r_prio);
  assign w_rbeat   = RVALID_M & RREADY_M;
  assign w_len_ext = {1'b0, r_len};

  // Acceptance is combinational so a request is taken in the cycle it is seen.
  assign ARREADY_M0 = w_idle & w_win0 & ~rst;
  assign ARREADY_M1 = w_idle & w_win1 & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_prio    <= 1'b0;
      r_beats   <= '0;
      r_ids     <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_valid   <= 1'b0;
      r_grant   <= 2'b00;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_win0 | w_win1) begin
            r_ids   <= w_win1 ? {c_tag_m1, ARID_M1} : {c_tag_m0, ARID_M0};
            r_addr  <= w_win1 ? ARADDR_M1  : ARADDR_M0;
            r_len   <= w_win1 ? ARLEN_M1   : ARLEN_M0;
            r_size  <= w_win1 ? ARSIZE_M1  : ARSIZE_M0;
            r_burst <= w_win1 ? ARBURST_M1 : ARBURST_M0;
            r_grant <= {w_win1, w_win0};
            r_prio  <= w_win0;
            r_valid <= 1'b1;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (READY_M) begin
            r_valid <= 1'b0;
            r_beats <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_rbeat) begin
            if (RLAST_M) begin
              r_len_err <= (r_beats != w_len_ext);
              r_grant   <= 2'b00;
              r_state   <= S_IDLE;
            end else begin
              if (r_beats == w_len_ext) begin
                r_len_err <= 1'b1;
              end
              // Saturate one past LEN so an overlong burst can never wrap back to a match.
              if (r_beats <= w_len_ext) begin
                r_beats <= r_beats + c_one;
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign IDS_M   = r_ids;
  assign ADDR_M  = r_addr;
  assign LEN_M   = r_len;
  assign SIZE_M  = r_size;
  assign BURST_M = r_burst;
  assign VALID_M = r_valid;
  assign grant   = r_grant;
  assign busy    = ~w_idle;
  assign len_err = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_ar_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ar_rr_arbiter
// Purpose  : Directed and random checks of ar_rr_arbiter against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ar_rr_arbiter;

  localparam int ID_BITS   = 4;
  localparam int ADDR_BITS = 32;
  localparam int LEN_BITS  = 4;
  localparam int SIZE_BITS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [ID_BITS-1:0]   ARID_M0, ARID_M1;
  logic [ADDR_BITS-1:0] ARADDR_M0, ARADDR_M1;
  logic [LEN_BITS-1:0]  ARLEN_M0, ARLEN_M1;
  logic [SIZE_BITS-1:0] ARSIZE_M0, ARSIZE_M1;
  logic [1:0]           ARBURST_M0, ARBURST_M1;
  logic                 ARVALID_M0, ARVALID_M1;
  logic                 ARREADY_M0, ARREADY_M1;
  logic [ID_BITS+3:0]   IDS_M;
  logic [ADDR_BITS-1:0] ADDR_M;
  logic [LEN_BITS-1:0]  LEN_M;
  logic [SIZE_BITS-1:0] SIZE_M;
  logic [1:0]           BURST_M;
  logic                 VALID_M, READY_M;
  logic                 RVALID_M, RREADY_M, RLAST_M;
  logic [1:0]           grant;
  logic                 busy, len_err;

  ar_rr_arbiter #(
    .ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS), .SIZE_BITS(SIZE_BITS)
  ) dut (
    .clk(clk), .rst(rst),
    .ARID_M0(ARID_M0), .ARID_M1(ARID_M1),
    .ARADDR_M0(ARADDR_M0), .ARADDR_M1(ARADDR_M1),
    .ARLEN_M0(ARLEN_M0), .ARLEN_M1(ARLEN_M1),
    .ARSIZE_M0(ARSIZE_M0), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M0(ARBURST_M0), .ARBURST_M1(ARBURST_M1),
    .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
    .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1),
    .IDS_M(IDS_M), .ADDR_M(ADDR_M), .LEN_M(LEN_M), .SIZE_M(SIZE_M), .BURST_M(BURST_M),
    .VALID_M(VALID_M), .READY_M(READY_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M), .RLAST_M(RLAST_M),
    .grant(grant), .busy(busy), .len_err(len_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding read, described as a transaction record.
  bit                   m_busy, m_apend, m_owner, m_err;
  bit                   m_last = 1'b1;  // last winner; starting at M1 lets M0 win the first tie
  int                   m_beats;
  logic [ID_BITS+3:0]   m_ids;
  logic [ADDR_BITS-1:0] m_addr;
  logic [LEN_BITS-1:0]  m_len;
  logic [SIZE_BITS-1:0] m_size;
  logic [1:0]           m_burst;

  function automatic int pick();
    if (ARVALID_M0 && ARVALID_M1) return m_last ? 0 : 1;
    if (ARVALID_M0) return 0;
    if (ARVALID_M1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_apend = 0; m_owner = 0; m_err = 0; m_last = 1; m_beats = 0;
    m_ids = '0; m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
  endtask

  task automatic model_step();
    bit err_next;
    int w;
    err_next = 0;
    w = pick();
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1; m_apend = 1; m_owner = w[0]; m_last = w[0];
        m_ids   = (w == 1) ? {4'b0010, ARID_M1} : {4'b0001, ARID_M0};
        m_addr  = (w == 1) ? ARADDR_M1  : ARADDR_M0;
        m_len   = (w == 1) ? ARLEN_M1   : ARLEN_M0;
        m_size  = (w == 1) ? ARSIZE_M1  : ARSIZE_M0;
        m_burst = (w == 1) ? ARBURST_M1 : ARBURST_M0;
      end
    end else if (m_apend) begin
      if (READY_M) begin
        m_apend = 0;
        m_beats = 0;
      end
    end else if (RVALID_M && RREADY_M) begin
      if (RLAST_M) begin
        err_next = (m_beats != int'(m_len));
        m_busy = 0;
      end else begin
        if (m_beats == int'(m_len)) err_next = 1;
        m_beats++;
      end
    end
    m_err = err_next;
  endtask

  task automatic check_outputs();
    int w;
    w = pick();
    chk("arready_m0", ARREADY_M0, !rst && !m_busy && w == 0);
    chk("arready_m1", ARREADY_M1, !rst && !m_busy && w == 1);
    chk("valid_m",    VALID_M,    m_busy && m_apend);
    chk("ids_m",      IDS_M,      m_ids);
    chk("addr_m",     ADDR_M,     m_addr);
    chk("len_m",      LEN_M,      m_len);
    chk("size_m",     SIZE_M,     m_size);
    chk("burst_m",    BURST_M,    m_burst);
    chk("grant",      grant,      m_busy ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
    chk("busy",       busy,       m_busy);
    chk("len_err",    len_err,    m_err);
  endtask

  // Called 1 time unit after a rising edge with this cycle's inputs already driven.
  task automatic tick();
    if (rst) model_reset();
    #4;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    ARVALID_M0 = 0; ARVALID_M1 = 0; READY_M = 0;
    RVALID_M = 0; RREADY_M = 0; RLAST_M = 0;
  endtask

  task automatic finish_burst();
    for (int i = 0; i < 64 && m_busy; i++) begin
      READY_M = 1; RVALID_M = 1; RREADY_M = 1;
      RLAST_M = (!m_apend && m_beats == int'(m_len));
      tick();
    end
    chk("burst_done", busy, 1'b0);
    clear_inputs();
  endtask

  logic [1:0]           exp_g [3];
  logic [ADDR_BITS-1:0] bp_addr;

  initial begin
    clear_inputs();
    ARID_M0 = '0; ARID_M1 = '0; ARADDR_M0 = '0; ARADDR_M1 = '0;
    ARLEN_M0 = '0; ARLEN_M1 = '0; ARSIZE_M0 = '0; ARSIZE_M1 = '0;
    ARBURST_M0 = '0; ARBURST_M1 = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset then idle
    rst = 1;
    repeat (3) tick();
    rst = 0;
    repeat (2) tick();
    chk("idle_grant", grant, 2'b00);

    // M0 alone, 4-beat burst
    ARVALID_M0 = 1; ARADDR_M0 = 32'h0001_0000; ARLEN_M0 = 4'd3; ARID_M0 = 4'd5;
    ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1;
    tick();
    chk("m0_valid", VALID_M, 1'b1);
    chk("m0_ids", IDS_M, 8'h15);
    chk("m0_addr", ADDR_M, 32'h0001_0000);
    ARVALID_M0 = 0;
    repeat (2) tick();
    chk("m0_addr_held", ADDR_M, 32'h0001_0000);
    READY_M = 1; tick(); READY_M = 0;
    for (int i = 0; i < 4; i++) begin
      RVALID_M = 1; RREADY_M = 1; RLAST_M = (i == 3);
      tick();
    end
    clear_inputs();
    chk("m0_idle", busy, 1'b0);
    chk("m0_no_len_err", len_err, 1'b0);

    // Both masters requesting: grants alternate 01, 10, 01
    rst = 1; tick(); rst = 0;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    ARVALID_M0 = 1; ARVALID_M1 = 1; ARLEN_M0 = 0; ARLEN_M1 = 0; ARID_M0 = 1; ARID_M1 = 2;
    READY_M = 1; RVALID_M = 1; RREADY_M = 1; RLAST_M = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rr_grant", grant, exp_g[k]);
      tick();
      tick();
    end
    clear_inputs();
    tick();

    // Slave backpressure for 5 cycles while M0 keeps requesting
    ARVALID_M1 = 1; ARADDR_M1 = 32'hCAFE_0040; ARLEN_M1 = 4'd2; bp_addr = ARADDR_M1;
    tick();
    ARVALID_M1 = 0; ARVALID_M0 = 1; ARADDR_M1 = 32'h0; ARADDR_M0 = 32'h1234_5678;
    repeat (5) begin
      tick();
      chk("bp_valid", VALID_M, 1'b1);
      chk("bp_addr", ADDR_M, bp_addr);
      chk("bp_arready", {ARREADY_M1, ARREADY_M0}, 2'b00);
    end
    ARVALID_M0 = 0; READY_M = 1;
    tick();
    chk("bp_valid_drop", VALID_M, 1'b0);
    chk("bp_in_data", busy, 1'b1);
    finish_burst();

    // RLAST early: LEN 1, RLAST on the first beat
    ARVALID_M0 = 1; ARLEN_M0 = 4'd1; tick(); ARVALID_M0 = 0;
    READY_M = 1; tick(); READY_M = 0;
    RVALID_M = 1; RREADY_M = 1; RLAST_M = 1; tick(); clear_inputs();
    chk("short_len_err", len_err, 1'b1);
    chk("short_idle", busy, 1'b0);
    tick();
    chk("short_pulse_width", len_err, 1'b0);

    // Overrun: LEN 0, no RLAST on the first beat
    ARVALID_M0 = 1; ARLEN_M0 = 4'd0; tick(); ARVALID_M0 = 0;
    READY_M = 1; tick(); READY_M = 0;
    RVALID_M = 1; RREADY_M = 1; RLAST_M = 0; tick(); clear_inputs();
    chk("over_len_err", len_err, 1'b1);
    chk("over_stays_data", busy, 1'b1);
    tick();
    chk("over_pulse_width", len_err, 1'b0);
    chk("over_still_data", busy, 1'b1);
    RVALID_M = 1; RREADY_M = 1; RLAST_M = 1; tick(); clear_inputs();
    chk("over_done", busy, 1'b0);
    tick();

    // Reset during DATA after 2 of 4 beats
    ARVALID_M0 = 1; ARLEN_M0 = 4'd3; tick(); ARVALID_M0 = 0;
    READY_M = 1; tick(); READY_M = 0;
    RVALID_M = 1; RREADY_M = 1; RLAST_M = 0;
    repeat (2) tick();
    clear_inputs();
    rst = 1; tick();
    chk("rst_valid", VALID_M, 1'b0);
    chk("rst_grant", grant, 2'b00);
    rst = 0; tick();
    chk("rst_no_len_err", len_err, 1'b0);
    ARVALID_M1 = 1; ARLEN_M1 = 4'd1; tick(); ARVALID_M1 = 0;
    chk("rst_m1_grant", grant, 2'b10);
    finish_burst();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      ARVALID_M0 = $urandom_range(0, 1);
      ARVALID_M1 = $urandom_range(0, 1);
      ARID_M0    = ID_BITS'($urandom);
      ARID_M1    = ID_BITS'($urandom);
      ARADDR_M0  = $urandom;
      ARADDR_M1  = $urandom;
      ARLEN_M0   = LEN_BITS'($urandom_range(0, 3));
      ARLEN_M1   = LEN_BITS'($urandom_range(0, 3));
      ARSIZE_M0  = SIZE_BITS'($urandom);
      ARSIZE_M1  = SIZE_BITS'($urandom);
      ARBURST_M0 = 2'($urandom);
      ARBURST_M1 = 2'($urandom);
      READY_M    = $urandom_range(0, 1);
      RVALID_M   = ($urandom_range(0, 3) != 0);
      RREADY_M   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) RLAST_M = $urandom_range(0, 1);
      else RLAST_M = (!m_apend && m_beats == int'(m_len));
      tick();
    end
    rst = 0;
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
